// File: rtl/img2col_ram_reader_if.sv
// RAM read port plus im2col element stream between the reader and its environment.
// The master side is the reader; the slave side is the RAM model and the downstream consumer.
interface img2col_ram_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 10
);
    logic [ADDR_SIZE-1:0]  ram_addra;
    logic                  ram_ena;
    logic                  ram_wea;
    logic [DATA_WIDTH-1:0] ram_dina;
    logic [DATA_WIDTH-1:0] ram_douta;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_patch_last;
    logic                  m_last;

    modport master (
        output ram_addra, ram_ena, ram_wea, ram_dina,
        input  ram_douta,
        output m_valid, m_data, m_patch_last, m_last,
        input  m_ready
    );

    modport slave (
        input  ram_addra, ram_ena, ram_wea, ram_dina,
        output ram_douta,
        input  m_valid, m_data, m_patch_last, m_last,
        output m_ready
    );
endinterface

// File: rtl/img2col_ram_reader.sv
// Walks a row-major IMG_H x IMG_W map in RAM and streams KxK stride-1 im2col patches.
// Reads are credit-limited so the 2-entry output FIFO can never overflow under backpressure.
module img2col_ram_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 10,
    parameter int IMG_H      = 4,
    parameter int IMG_W      = 4,
    parameter int K          = 3
) (
    input  logic clka,
    input  logic rsta,
    input  logic start,
    output logic busy,
    output logic done,
    img2col_ram_reader_if.master bus
);
    localparam int OH = IMG_H - K + 1;
    localparam int OW = IMG_W - K + 1;
    localparam int CW = $clog2((IMG_H > IMG_W) ? IMG_H : IMG_W) + 1;
    localparam logic [CW-1:0]        K_M1  = CW'(K - 1);
    localparam logic [CW-1:0]        OH_M1 = CW'(OH - 1);
    localparam logic [CW-1:0]        OW_M1 = CW'(OW - 1);
    localparam logic [ADDR_SIZE-1:0] W_A   = ADDR_SIZE'(IMG_W);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    typedef struct packed {
        logic                  last;
        logic                  patch_last;
        logic [DATA_WIDTH-1:0] data;
    } elem_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
    elem_t [1:0]     fifo_q, fifo_d;
    logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            infl_q, infl_d;
    logic [1:0]      infl_tag_q, infl_tag_d;   // {last, patch_last} of the read in flight

    logic                 issue, pop, push, last_k, last_o, valid;
    logic [2:0]           credit;
    logic [ADDR_SIZE-1:0] addr;
    elem_t                head;

    always_comb begin
        state_d    = state_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;

        valid  = (cnt_q != 2'd0);
        pop    = valid & bus.m_ready;
        push   = infl_q;
        last_k = (kx_q == K_M1) && (ky_q == K_M1);
        last_o = (ox_q == OW_M1) && (oy_q == OH_M1);
        addr   = (ADDR_SIZE'(oy_q) + ADDR_SIZE'(ky_q)) * W_A + ADDR_SIZE'(ox_q) + ADDR_SIZE'(kx_q);

        // Occupancy after this cycle's pop, counting the read whose data lands next cycle.
        credit = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
        issue  = (state_q == S_ISSUE) && (credit < 3'd2);

        infl_d     = issue;
        infl_tag_d = {last_k && last_o, last_k};

        if (push) begin
            fifo_d[wr_ptr_q] = '{last: infl_tag_q[1], patch_last: infl_tag_q[0], data: bus.ram_douta};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

        if (issue) begin
            if (kx_q == K_M1) begin
                kx_d = '0;
                if (ky_q == K_M1) begin
                    ky_d = '0;
                    if (ox_q == OW_M1) begin
                        ox_d = '0;
                        oy_d = (oy_q == OH_M1) ? '0 : oy_q + 1'b1;
                    end else begin
                        ox_d = ox_q + 1'b1;
                    end
                end else begin
                    ky_d = ky_q + 1'b1;
                end
            end else begin
                kx_d = kx_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: if (issue && last_k && last_o) state_d = S_DRAIN;
            S_DRAIN: if (cnt_d == 2'd0 && !infl_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q    <= S_IDLE;
            kx_q       <= '0;
            ky_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            fifo_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            infl_q     <= 1'b0;
            infl_tag_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            infl_q     <= infl_d;
            infl_tag_q <= infl_tag_d;
        end
    end

    assign head             = fifo_q[rd_ptr_q];
    assign bus.m_valid      = valid;
    assign bus.m_data       = valid ? head.data : '0;
    assign bus.m_patch_last = valid & head.patch_last;
    assign bus.m_last       = valid & head.last;
    assign bus.ram_ena      = issue;
    assign bus.ram_addra    = issue ? addr : '0;
    assign bus.ram_wea      = 1'b0;
    assign bus.ram_dina     = '0;
    assign busy             = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done             = (state_q == S_DONE);
endmodule

// File: doc/img2col_ram_reader.md
Name: img2col_ram_reader

Overview:
- Read-side initiator for the single-port tensor RAM (the `ram_t0` style port: clka/addra/ena/wea/dina/douta, 1-cycle registered read).
- On a start pulse, walks an IMG_H x IMG_W single-channel feature map stored row-major at address 0.
- Emits the im2col patch stream for a KxK kernel (stride 1, no padding) over a valid/ready interface toward the GEMM operand loader.

Parameters:
- DATA_WIDTH, 8, element width; matches RAM data width.
- ADDR_SIZE, 10, RAM address width.
- IMG_H, 4, feature-map rows.
- IMG_W, 4, feature-map columns.
- K, 3, kernel size. Legal range: 1 <= K <= min(IMG_H, IMG_W). IMG_H*IMG_W <= 2^ADDR_SIZE.

Ports:
- clka  in  1  clock; all logic on rising edge.
- rsta  in  1  synchronous active-high reset.
- start  in  1  begin one full traversal; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final element is accepted downstream.
- ram_addra  out  ADDR_SIZE  RAM read address.
- ram_ena  out  1  RAM enable; high only on cycles issuing a read.
- ram_wea  out  1  constant 0.
- ram_dina  out  DATA_WIDTH  constant 0.
- ram_douta  in  DATA_WIDTH  RAM read data, valid the cycle after ram_ena.
- m_valid  out  1  output element valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  element value.
- m_patch_last  out  1  marks the last element (ky=K-1, kx=K-1) of each patch.
- m_last  out  1  marks the final element of the whole traversal.

Behaviour:
- Reset values:
  - busy, done, ram_ena, m_valid, m_patch_last, m_last = 0.
  - ram_addra = 0; m_data = 0.
  - All counters = 0; output buffer empty; FSM in IDLE.
- Geometry:
  - OH = IMG_H-K+1, OW = IMG_W-K+1.
  - Total elements N = OH*OW*K*K.
- Ordering:
  - Outer loop over oy, then ox (row-major).
  - Inner loop over ky, then kx (row-major).
  - Address = (oy+ky)*IMG_W + (ox+kx).
  - Address arithmetic uses ADDR_SIZE bits; with legal parameters it cannot overflow.
- FSM:
  - IDLE: wait for start. On start=1, go to ISSUE. start while busy is ignored.
  - ISSUE: issue reads subject to the credit rule below. Advance kx -> ky -> ox -> oy counters once per issued read. After the read for element N-1 is issued, go to DRAIN.
  - DRAIN: no further reads. Stay until the buffer is empty and no read is in flight, with the last element accepted.
  - DONE: one cycle; done=1, busy=0; return to IDLE.
- Credit and buffering:
  - 2-entry output FIFO, plus a 1-bit in-flight flag for the read issued last cycle.
  - A read is issued in cycle t only if (fifo_count - pop_t + inflight_t) < 2, where pop_t = m_valid & m_ready.
  - RAM data is written into the FIFO the cycle after ram_ena.
  - Data is never dropped or duplicated under any m_ready pattern.
- Throughput and latency:
  - With m_ready held high, one element per cycle sustained.
  - First ram_ena is in the cycle after start is sampled.
  - First m_valid is 2 cycles after the first ram_ena.
- Output stability:
  - m_data, m_patch_last and m_last come from the FIFO head.
  - While m_valid=1 and m_ready=0, they hold stable.
  - m_valid never deasserts without a handshake.
- Flags:
  - m_patch_last=1 exactly on every K*K-th element.
  - m_last=1 only on element N-1; m_patch_last is also 1 on that element.
- K=1: every element has m_patch_last=1; the stream equals the RAM contents 0..IMG_H*IMG_W-1 in order.
- Reset mid-operation:
  - rsta has priority over everything.
  - Next cycle: IDLE, FIFO flushed, the in-flight read discarded, all outputs at reset values.
  - A returning douta after reset is ignored.
- start in the same cycle as DONE: ignored, because the FSM is not in IDLE.
- start the cycle after DONE: accepted.

Test Plan:
- Defaults (4x4, K=3); RAM mem[i]=i; m_ready=1; start pulse:
  - 36 elements: 0,1,2,4,5,6,8,9,10 | 1,2,3,5,6,7,9,10,11 | 4,5,6,8,9,10,12,13,14 | 5,6,7,9,10,11,13,14,15.
  - m_patch_last on elements 8, 17, 26, 35; m_last on element 35 (value 15).
  - done pulses once; first m_valid exactly 3 cycles after the start edge.
- Same stimulus, m_ready toggled 1,0,0,1 repeating and random:
  - Identical 36-value sequence; m_data is stable while stalled.
  - ram_ena never issues when FIFO count plus in-flight reads would exceed 2.
- m_ready held 0 for 20 cycles after start:
  - Exactly 2 reads are issued; m_valid=1 with m_data=0 held.
  - After release, the sequence continues with 1,2,4,...
- rsta asserted for 1 cycle after the 10th accepted element:
  - All outputs go to 0 and the FSM returns to IDLE.
  - A new start replays the stream from value 0.
- Rebuild with K=1, IMG 3x3:
  - Stream is 0..8, m_patch_last=1 on every element, m_last on value 8.
- Pulse start at every cycle while busy:
  - Only one traversal of 36 elements; exactly one done pulse.
  - A start one cycle after done begins a second identical traversal.
